// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between requesters A and B, plus a zeroing clear sequence.
// Latency: grant and memory strobes are combinational; read data returns one cycle after the accepting edge.
// Backpressure: ready is withheld from the losing requester, on a clr_req cycle, throughout CLEAR and in reset.

module mem_port_arbiter #(
  parameter int WIDTH = 2,
  parameter int PSIZE = 2,
  parameter int DEPTH = 2**PSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic             a_wr,
  input  logic [PSIZE-1:0] a_addr,
  input  logic [WIDTH-1:0] a_wdata,
  output logic             a_ready,
  output logic             a_rvalid,
  output logic [WIDTH-1:0] a_rdata,
  input  logic             b_valid,
  input  logic             b_wr,
  input  logic [PSIZE-1:0] b_addr,
  input  logic [WIDTH-1:0] b_wdata,
  output logic             b_ready,
  output logic             b_rvalid,
  output logic [WIDTH-1:0] b_rdata,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             mem_wr,
  output logic             mem_rd,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [PSIZE-1:0] mem_wr_addr,
  output logic [PSIZE-1:0] mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic {ST_ARB, ST_CLEAR} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_prio;        // 0: A wins a tie, 1: B wins a tie
  logic             w_prio_nxt;
  logic [PSIZE-1:0] r_clr_cnt;
  logic [PSIZE-1:0] w_clr_cnt_nxt;
  logic             r_a_rvalid;
  logic             r_b_rvalid;
  logic             w_gnt_a;
  logic             w_gnt_b;

  // State, priority, clear counter and read-return flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_ARB;
      r_prio     <= 1'b0;
      r_clr_cnt  <= '0;
      r_a_rvalid <= 1'b0;
      r_b_rvalid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_prio     <= w_prio_nxt;
      r_clr_cnt  <= w_clr_cnt_nxt;
      r_a_rvalid <= w_gnt_a & ~a_wr;
      r_b_rvalid <= w_gnt_b & ~b_wr;
    end
  end

  // Grant selection, memory drive and next-state; nothing is granted or strobed while rst_n is low.
  always_comb begin
    w_state_nxt   = r_state;
    w_prio_nxt    = r_prio;
    w_clr_cnt_nxt = r_clr_cnt;
    w_gnt_a       = 1'b0;
    w_gnt_b       = 1'b0;
    clr_busy      = 1'b0;
    mem_wr        = 1'b0;
    mem_rd        = 1'b0;
    mem_wdata     = '0;
    mem_wr_addr   = '0;
    mem_rd_addr   = '0;
    case (r_state)
      ST_ARB: begin
        if (rst_n) begin
          if (clr_req) begin
            w_state_nxt = ST_CLEAR;
          end else if (a_valid && (!b_valid || !r_prio)) begin
            w_gnt_a = 1'b1;
          end else if (b_valid) begin
            w_gnt_b = 1'b1;
          end
        end
        if (w_gnt_a) begin
          w_prio_nxt  = 1'b1;
          mem_wr      = a_wr;
          mem_rd      = ~a_wr;
          mem_wr_addr = a_addr;
          mem_rd_addr = a_addr;
          mem_wdata   = a_wdata;
        end else if (w_gnt_b) begin
          w_prio_nxt  = 1'b0;
          mem_wr      = b_wr;
          mem_rd      = ~b_wr;
          mem_wr_addr = b_addr;
          mem_rd_addr = b_addr;
          mem_wdata   = b_wdata;
        end
      end
      ST_CLEAR: begin
        // One zero write per cycle; the edge retiring the last address returns to ARB.
        clr_busy      = 1'b1;
        mem_wr        = rst_n;
        mem_wr_addr   = r_clr_cnt;
        w_clr_cnt_nxt = r_clr_cnt + PSIZE'(1);
        if (r_clr_cnt == PSIZE'(DEPTH - 1)) begin
          w_state_nxt   = ST_ARB;
          w_clr_cnt_nxt = '0;
        end
      end
      default: ;
    endcase
  end

  assign a_ready  = w_gnt_a;
  assign b_ready  = w_gnt_b;
  assign a_rvalid = r_a_rvalid;
  assign b_rvalid = r_b_rvalid;
  assign a_rdata  = mem_rdata;
  assign b_rdata  = mem_rdata;

  // The memory cannot take a write and a read in the same cycle.
  a_wr_rd_excl: assert property (@(posedge clk) !(mem_wr && mem_rd));

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one single-port-style memory between two requesters, A and B.
- The memory has separate write/read strobes that must never be asserted together, and a 1-cycle registered read.
- The block guarantees write/read mutual exclusion, returns read data to the requester that issued the read, and provides a clear sequence that zeroes every memory word.
- It sits directly in front of the memory instance. The memory is reset from the same rst_n.

Parameters:
- WIDTH, 2, data word width (even).
- PSIZE, 2, address width.
- DEPTH, 2**PSIZE, number of memory words.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  reset; synchronous, active-low.
- a_valid  in  1  requester A has a request.
- a_wr  in  1  1 = write, 0 = read.
- a_addr  in  PSIZE  request address.
- a_wdata  in  WIDTH  write data.
- a_ready  out  1  A's request is accepted this cycle.
- a_rvalid  out  1  A's read data is valid.
- a_rdata  out  WIDTH  read data for A.
- b_valid, b_wr, b_addr, b_wdata, b_ready, b_rvalid, b_rdata: same as the A ports, for requester B.
- clr_req  in  1  start a clear sequence (sampled only in ARB).
- clr_busy  out  1  clear sequence in progress.
- mem_wr  out  1  memory write strobe.
- mem_rd  out  1  memory read strobe.
- mem_wdata  out  WIDTH  memory write data.
- mem_wr_addr  out  PSIZE  memory write address.
- mem_rd_addr  out  PSIZE  memory read address.
- mem_rdata  in  WIDTH  memory registered read data.

Behaviour:
- Reset (rst_n low at posedge):
  - state = ARB, prio = A, clear counter = 0.
  - a_rvalid = b_rvalid = 0, clr_busy = 0.
  - While rst_n is low: a_ready = b_ready = 0 and mem_wr = mem_rd = 0.
  - Reset mid-CLEAR or with a read in flight aborts it; no rvalid is produced.
- States: ARB, CLEAR.
- ARB, arbitration (combinational grant):
  - If clr_req = 1, grant nothing this cycle and go to CLEAR next cycle.
  - Otherwise, if only one requester is valid, grant it.
  - If both are valid, grant the one prio points to.
  - After any grant, prio points to the non-granted requester.
  - x_ready = grant to x. A transfer happens when x_valid & x_ready.
  - At most one grant per cycle.
- Memory drive (combinational from the granted request):
  - Write grant: mem_wr = 1, mem_wr_addr = addr, mem_wdata = wdata, mem_rd = 0.
  - Read grant: mem_rd = 1, mem_rd_addr = addr, mem_wr = 0.
  - No grant: both strobes 0.
  - mem_wr & mem_rd is never 1. This is checked by assertion.
- Read return:
  - A read accepted at edge N produces x_rvalid = 1 for exactly one cycle after edge N, with x_rdata = mem_rdata.
  - a_rdata and b_rdata pass mem_rdata through; their value is don't-care when rvalid = 0.
  - Back-to-back reads are allowed. Reads return in order, one per cycle.
- Write visibility: a write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Data transform: the arbiter does not alter data. The memory half-swaps words stored at addresses ≥ DEPTH/2, and that is visible to requesters.
- CLEAR:
  - Lasts exactly DEPTH cycles. In each cycle: mem_wr = 1, mem_wr_addr = counter, mem_wdata = 0, mem_rd = 0.
  - The counter increments 0..DEPTH-1, then wraps to 0. State returns to ARB on the edge that retires address DEPTH-1.
  - clr_busy = 1 throughout CLEAR; a_ready = b_ready = 0.
  - clr_req during CLEAR is ignored.
  - A read accepted in the cycle before CLEAR still returns its rvalid in the first CLEAR cycle.
  - prio is unchanged by CLEAR.
- Invalid-request rule: a requester must hold valid and its fields stable until ready. The arbiter does not check this.

Test Plan (WIDTH=2, PSIZE=2):
- A writes addr 1 data 2'b10, then A reads addr 1 -> a_rvalid one cycle after the read handshake, a_rdata = 2'b10, b_rvalid stays 0.
- B writes addr 3 data 2'b01, then reads addr 3 -> b_rdata = 2'b10 (memory swap passes through unmodified).
- a_valid = b_valid = 1 (reads) held for 4 cycles after reset -> grants A, B, A, B; mem_rd = 1 and mem_wr = 0 every cycle; rvalid alternates a/b.
- A writes on every cycle while B reads on every cycle -> mem_wr and mem_rd are never both 1; each requester is served every other cycle.
- Fill addrs 0..3 with 2'b11, pulse clr_req -> clr_busy = 1 for 4 cycles, mem_wr_addr = 0, 1, 2, 3 with data 0, readies 0; then reads of all addrs return 0.
- rst_n low during CLEAR cycle 2 -> next cycle state ARB, clr_busy = 0, no rvalid; after rst_n returns high, a single A request is granted immediately.
